module3_arbiter: RTL and testbench
==================================

# module3_arbiter

Round-robin controller that shares one `module3` datapath instance between `NOF_REQ` requesters. It grants the datapath to one requester at a time for a bounded burst and drives the datapath enable and data. It also tracks ownership of in-flight beats, so each datapath result returns only to the requester that issued it. It sits directly in front of `module3`, replacing the point-to-point connection to its `enable_i`/`data_i`/`data_o`.

## Interface
- `WIDTH`, 8: datapath word width; must match the shared `module3` instance.
- `NOF_REQ`, 4: number of requesters; ≥ 2.
- `MAX_BURST`, 4: maximum beats per grant; ≥ 1.
- `DP_LATENCY`, 1: cycles from `dp_enable_o` beat to valid `dp_data_i`; ≥ 1.
- `clk_i` in 1: single clock, all logic rising-edge.
- `rst_ni` in 1: asynchronous active-low reset.
- `req_valid_i` in NOF_REQ: per-requester beat valid.
- `req_last_i` in NOF_REQ: per-requester last beat of burst.
- `req_data_i` in NOF_REQ*WIDTH: requester k data at bits [k*WIDTH +: WIDTH].
- `req_ready_o` out NOF_REQ: per-requester beat accepted; at most one bit set.
- `dp_enable_o` out 1: datapath beat strobe.
- `dp_data_o` out WIDTH: datapath input word.
- `dp_data_i` in WIDTH: datapath result word.
- `rsp_valid_o` out NOF_REQ: one-hot result valid for the owning requester.
- `rsp_data_o` out WIDTH: result word, shared by all requesters.

## Operation
- Beat handshake: a beat transfers when `req_valid_i[k] && req_ready_o[k]`.
- `req_ready_o[k]` is high only while in GRANT with owner = k.
- `dp_enable_o` = transfer of the owner (combinational).
- `dp_data_o` = owner's data slice, valid only with `dp_enable_o`. Otherwise drive 0.
- FSM states: IDLE, GRANT.
- IDLE → GRANT: taken when any `req_valid_i` is high.
  - Owner = first requester with valid high, searching upward (with wrap) from `rr_ptr`.
  - Beat counter cleared.
- GRANT → IDLE, when any of these holds:
  - a transfer with `req_last_i[owner]` high;
  - a transfer with beat count reaching `MAX_BURST`;
  - a cycle with `req_valid_i[owner]` low (a gap terminates the burst).
- On the GRANT → IDLE transition, `rr_ptr` ← (owner + 1) mod NOF_REQ.
- Reset value of `rr_ptr` is 0.
- Beat counter width is `$clog2(MAX_BURST+1)`. It saturates at `MAX_BURST` and never wraps.
- Owner ID width is `$clog2(NOF_REQ)`.
- Ownership pipeline: `DP_LATENCY` stages of {valid, owner ID}, loaded on each `dp_enable_o`.
- At the pipeline tail, `rsp_valid_o[id]` = 1 and `rsp_data_o` = `dp_data_i`, registered pass-through of the tail stage. Otherwise `rsp_valid_o` = 0 and `rsp_data_o` = 0.
- In-flight results are delivered regardless of later grant changes.

## Timing
- Arbitration latency: valid seen in IDLE at cycle t gives `req_ready_o` high at t+1.
- Between consecutive bursts there is always exactly one IDLE cycle.
- Result latency: a beat at cycle t gives `rsp_valid_o` at t+DP_LATENCY+1.
- Back-to-back beats sustain 1 beat/cycle within a burst.
- Simultaneous requests are resolved by the `rr_ptr` order only. No requester waits more than NOF_REQ−1 bursts.
- Reset asserted (async) mid-burst:
  - FSM → IDLE, `rr_ptr` → 0.
  - Pipeline valids cleared; in-flight results are dropped.
- Reset values of all outputs: `req_ready_o` = 0, `dp_enable_o` = 0, `dp_data_o` = 0, `rsp_valid_o` = 0, `rsp_data_o` = 0.
- Reset deassertion is assumed synchronised externally.

## Configuration
- `MODULE3_ARBITER_STATS_EN`: when defined, the block adds two things.
  - Output port `stat_bursts_o` (16 bits): counts completed bursts (GRANT → IDLE transitions), wraps at 65535 → 0, resets to 0.
  - Output port `stat_conflicts_o` (16 bits): counts IDLE cycles with ≥ 2 requesters valid, same wrap and reset behaviour.
- When undefined, neither port nor counter exists. Functional behaviour is identical in both builds.

## Test plan
- Single requester 2, 3 beats (0x11, 0x22, 0x33), last on the 3rd:
  - ready at t+1..t+3; `dp_data_o` sequence 0x11, 0x22, 0x33;
  - `rsp_valid_o` = 4'b0100 for 3 cycles at DP_LATENCY+1 after each beat;
  - then IDLE.
- All 4 requesters continuously valid, no last, MAX_BURST = 4:
  - grant order 0, 1, 2, 3, 0, each 4 beats with one IDLE cycle between;
  - with stats enabled, `stat_bursts_o` = 5 after the fifth burst.
- Requester 1 drops valid after 2 beats:
  - burst ends, `rr_ptr` = 2;
  - requester 1 re-raising valid waits behind a valid requester 2.
- DP_LATENCY = 3; requester 0 sends 2 beats, then requester 3 sends 1:
  - results for 0 arrive after grant has moved to 3;
  - `rsp_valid_o` goes 0001, 0001, then 1000 only for 3's beat.
- `rst_ni` pulsed low mid-burst with 2 beats in flight:
  - all outputs 0 immediately;
  - no `rsp_valid_o` after release;
  - the next grant goes to the lowest-index valid requester.
- Stats build, wrap check: preload 65535 via 65535 bursts (or force); one more burst → `stat_bursts_o` = 0.

Source files
------------

// File: rtl/module3_arbiter_if.sv
// ---------------------------------------------------------------------------
// module3_arbiter_if
//
// Purpose: bundles the requester-side handshake, the shared datapath
// connection and the result return path of module3_arbiter into one
// interface, so the arbiter and its environment can be wired with a single
// connection.
//
// Parameters (must match the arbiter instance it is connected to):
//   WIDTH    datapath word width
//   NOF_REQ  number of requesters
//
// Signals:
//   req_valid_i  [NOF_REQ]        per-requester beat valid
//   req_last_i   [NOF_REQ]        per-requester last beat of burst
//   req_data_i   [NOF_REQ*WIDTH]  requester k data at [k*WIDTH +: WIDTH]
//   req_ready_o  [NOF_REQ]        per-requester beat accepted (at most one set)
//   dp_enable_o                   datapath beat strobe
//   dp_data_o    [WIDTH]          datapath input word
//   dp_data_i    [WIDTH]          datapath result word
//   rsp_valid_o  [NOF_REQ]        one-hot result valid for the owning requester
//   rsp_data_o   [WIDTH]          result word shared by all requesters
//
// Modports:
//   slave   the arbiter side
//   master  the environment side (requesters plus datapath)
// ---------------------------------------------------------------------------
interface module3_arbiter_if #(
    parameter int WIDTH   = 8,
    parameter int NOF_REQ = 4
);
    logic [NOF_REQ-1:0]       req_valid_i;
    logic [NOF_REQ-1:0]       req_last_i;
    logic [NOF_REQ*WIDTH-1:0] req_data_i;
    logic [NOF_REQ-1:0]       req_ready_o;
    logic                     dp_enable_o;
    logic [WIDTH-1:0]         dp_data_o;
    logic [WIDTH-1:0]         dp_data_i;
    logic [NOF_REQ-1:0]       rsp_valid_o;
    logic [WIDTH-1:0]         rsp_data_o;

    modport slave (
        input  req_valid_i, req_last_i, req_data_i, dp_data_i,
        output req_ready_o, dp_enable_o, dp_data_o, rsp_valid_o, rsp_data_o
    );

    modport master (
        output req_valid_i, req_last_i, req_data_i, dp_data_i,
        input  req_ready_o, dp_enable_o, dp_data_o, rsp_valid_o, rsp_data_o
    );
endinterface

// File: rtl/module3_arbiter.sv
// ---------------------------------------------------------------------------
// module3_arbiter
//
// Purpose: round-robin controller sharing one module3 datapath between
// NOF_REQ requesters. A requester is granted the datapath for a burst of at
// most MAX_BURST beats; the beat is forwarded to the datapath and the
// owner of every in-flight beat is tracked so each result is returned only
// to the requester that issued it.
//
// Parameters:
//   WIDTH       datapath word width (matches the shared module3)
//   NOF_REQ     number of requesters, >= 2
//   MAX_BURST   maximum beats per grant, >= 1
//   DP_LATENCY  cycles from a dp_enable_o beat to its valid dp_data_i, >= 1
//
// Ports:
//   clk_i    clock, rising edge
//   rst_ni   asynchronous active-low reset
//   bus      module3_arbiter_if.slave (requester, datapath and result signals)
//   stat_bursts_o    [16] completed bursts, wrapping (stats build only)
//   stat_conflicts_o [16] IDLE cycles with >= 2 requesters valid (stats build only)
//
// Configuration macro: MODULE3_ARBITER_STATS_EN adds the two statistics
// counters and their ports; the arbitration behaviour is identical either way.
// ---------------------------------------------------------------------------
module module3_arbiter #(
    parameter int WIDTH      = 8,
    parameter int NOF_REQ    = 4,
    parameter int MAX_BURST  = 4,
    parameter int DP_LATENCY = 1
) (
    input  logic clk_i,
    input  logic rst_ni,
`ifdef MODULE3_ARBITER_STATS_EN
    output logic [15:0] stat_bursts_o,
    output logic [15:0] stat_conflicts_o,
`endif
    module3_arbiter_if.slave bus
);
    localparam int OW = $clog2(NOF_REQ);
    localparam int CW = $clog2(MAX_BURST + 1);

    typedef enum logic [0:0] {IDLE, GRANT} arbState_t;

    arbState_t         r_state;
    arbState_t         w_nextState;
    logic [OW-1:0]     r_owner;
    logic [OW-1:0]     r_rrPtr;
    logic [CW-1:0]     r_beatCnt;
    logic              w_start;
    logic              w_endBurst;
    logic              w_xfer;
    logic              w_burstFull;
    logic [OW-1:0]     w_pick;
    logic [OW-1:0]     w_nextPtr;

    logic [DP_LATENCY-1:0] r_pipeValid;
    logic [OW-1:0]         r_pipeId [DP_LATENCY];
    logic                  w_tailValid;
    logic [OW-1:0]         w_tailId;
    logic [NOF_REQ-1:0]    r_rspValid;
    logic [WIDTH-1:0]      r_rspData;

    // First valid requester found by searching upward from the pointer with wrap.
    function automatic logic [OW-1:0] rrPick(input logic [NOF_REQ-1:0] valid,
                                             input logic [OW-1:0]      ptr);
        int  idx;
        logic found;
        rrPick = ptr;
        found  = 1'b0;
        for (int i = 0; i < NOF_REQ; i++) begin
            idx = (int'(ptr) + i) % NOF_REQ;
            if (!found && valid[idx]) begin
                rrPick = OW'(idx);
                found  = 1'b1;
            end
        end
    endfunction

    assign w_pick      = rrPick(bus.req_valid_i, r_rrPtr);
    assign w_nextPtr   = (r_owner == OW'(NOF_REQ - 1)) ? '0 : r_owner + 1'b1;
    assign w_xfer      = (r_state == GRANT) && bus.req_valid_i[r_owner];
    // The beat being transferred now is the one that fills the burst.
    assign w_burstFull = (r_beatCnt == CW'(MAX_BURST - 1));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next state plus the grant-side outputs, all derived from the current owner.
    always_comb begin
        w_nextState     = r_state;
        w_start         = 1'b0;
        w_endBurst      = 1'b0;
        bus.req_ready_o = '0;
        bus.dp_enable_o = w_xfer;
        bus.dp_data_o   = '0;
        case (r_state)
            IDLE: begin
                if (|bus.req_valid_i) begin
                    w_nextState = GRANT;
                    w_start     = 1'b1;
                end
            end
            GRANT: begin
                bus.req_ready_o = {{(NOF_REQ-1){1'b0}}, 1'b1} << r_owner;
                if (w_xfer) begin
                    bus.dp_data_o = bus.req_data_i[int'(r_owner)*WIDTH +: WIDTH];
                end
                // A gap, a last beat or a full burst all release the grant.
                if (!w_xfer || bus.req_last_i[r_owner] || w_burstFull) begin
                    w_nextState = IDLE;
                    w_endBurst  = 1'b1;
                end
            end
            default: w_nextState = IDLE;
        endcase
    end

    // Owner, round-robin pointer and saturating beat counter.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_owner   <= '0;
            r_rrPtr   <= '0;
            r_beatCnt <= '0;
        end else begin
            if (w_start) begin
                r_owner   <= w_pick;
                r_beatCnt <= '0;
            end else if (w_xfer && (r_beatCnt != CW'(MAX_BURST))) begin
                r_beatCnt <= r_beatCnt + 1'b1;
            end
            if (w_endBurst) begin
                r_rrPtr <= w_nextPtr;
            end
        end
    end

    // Ownership pipeline runs every cycle so its tail lines up with dp_data_i.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_pipeValid <= '0;
            for (int i = 0; i < DP_LATENCY; i++) begin
                r_pipeId[i] <= '0;
            end
        end else begin
            r_pipeValid[0] <= w_xfer;
            r_pipeId[0]    <= r_owner;
            for (int i = 1; i < DP_LATENCY; i++) begin
                r_pipeValid[i] <= r_pipeValid[i-1];
                r_pipeId[i]    <= r_pipeId[i-1];
            end
        end
    end

    assign w_tailValid = r_pipeValid[DP_LATENCY-1];
    assign w_tailId    = r_pipeId[DP_LATENCY-1];

    // Registered result return, zero whenever no owned result is at the tail.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rspValid <= '0;
            r_rspData  <= '0;
        end else begin
            r_rspValid <= w_tailValid ? ({{(NOF_REQ-1){1'b0}}, 1'b1} << w_tailId) : '0;
            r_rspData  <= w_tailValid ? bus.dp_data_i : '0;
        end
    end

    assign bus.rsp_valid_o = r_rspValid;
    assign bus.rsp_data_o  = r_rspData;

`ifdef MODULE3_ARBITER_STATS_EN
    logic [15:0] r_statBursts;
    logic [15:0] r_statConflicts;
    logic        w_conflict;

    assign w_conflict = (r_state == IDLE) && ($countones(bus.req_valid_i) >= 2);

    // Both counters wrap naturally at 16 bits.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_statBursts    <= '0;
            r_statConflicts <= '0;
        end else begin
            if (w_endBurst) begin
                r_statBursts <= r_statBursts + 16'd1;
            end
            if (w_conflict) begin
                r_statConflicts <= r_statConflicts + 16'd1;
            end
        end
    end

    assign stat_bursts_o    = r_statBursts;
    assign stat_conflicts_o = r_statConflicts;
`else
    // Statistics build disabled: no counters and no statistics ports.
`endif
endmodule

// File: tb/tb_module3_arbiter.sv
// ---------------------------------------------------------------------------
// tb_module3_arbiter
//
// Purpose: self-checking bench for module3_arbiter (WIDTH 8, NOF_REQ 4,
// MAX_BURST 4, DP_LATENCY 3). A behavioural datapath (delayed XOR) sits on
// the dp side; a rule-level reference model predicts grants, datapath
// beats and result returns; directed scenarios are followed by random
// traffic. Honours MODULE3_ARBITER_STATS_EN for the statistics ports.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_module3_arbiter;
    localparam int W   = 8;
    localparam int N   = 4;
    localparam int MB  = 4;
    localparam int L   = 3;
    localparam logic [7:0] DP_KEY = 8'hA5;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    module3_arbiter_if #(.WIDTH(W), .NOF_REQ(N)) bus ();

`ifdef MODULE3_ARBITER_STATS_EN
    logic [15:0] statBursts;
    logic [15:0] statConflicts;
`endif

    module3_arbiter #(.WIDTH(W), .NOF_REQ(N), .MAX_BURST(MB), .DP_LATENCY(L)) dut (
        .clk_i            (clk),
        .rst_ni           (rst_n),
`ifdef MODULE3_ARBITER_STATS_EN
        .stat_bursts_o    (statBursts),
        .stat_conflicts_o (statConflicts),
`endif
        .bus              (bus)
    );

    // Behavioural datapath: result = input XOR key, L cycles later.
    logic [W-1:0] dpPipe [L];
    always @(posedge clk) begin
        dpPipe[0] <= bus.dp_data_o ^ DP_KEY;
        for (int i = 1; i < L; i++) dpPipe[i] <= dpPipe[i-1];
    end
    assign bus.dp_data_i = dpPipe[L-1];

    int nChecks = 0;
    int nFails  = 0;

    // Reference model state, expressed in terms of grants and bursts.
    typedef struct {
        int         due;
        int         id;
        logic [7:0] data;
    } rsp_t;
    rsp_t rspQ[$];
    bit   mGranted   = 1'b0;
    int   mOwner     = 0;
    int   mBeats     = 0;
    int   mPtr       = 0;
    int   mBursts    = 0;
    int   mConflicts = 0;
    int   cycle      = 0;

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nChecks++;
        assert (obs === exp) else begin
            nFails++;
            $error("[TB] FAIL %s: observed 'h%0h, expected 'h%0h (cycle %0d)", tag, obs, exp, cycle);
        end
    endtask

    task automatic modelReset();
        mGranted   = 1'b0;
        mOwner     = 0;
        mBeats     = 0;
        mPtr       = 0;
        mBursts    = 0;
        mConflicts = 0;
        rspQ.delete();
    endtask

    task automatic endBurst();
        mGranted = 1'b0;
        mPtr     = (mOwner + 1) % N;
        mBursts  = (mBursts + 1) % 65536;
    endtask

    // Compare every output with the model for this cycle, then advance the model.
    task automatic checkOutput();
        logic [3:0] expReady, expRspV;
        logic [7:0] expData, expRspD, slice;
        logic       xfer;
        int         nv;
        bit         found;
        expReady = mGranted ? 4'(1 << mOwner) : 4'b0;
        xfer     = mGranted && bus.req_valid_i[mOwner];
        slice    = bus.req_data_i[mOwner*W +: W];
        expData  = xfer ? slice : 8'h00;
        expRspV  = 4'b0;
        expRspD  = 8'h00;
        if (rspQ.size() > 0 && rspQ[0].due == cycle) begin
            expRspV = 4'(1 << rspQ[0].id);
            expRspD = rspQ[0].data;
            void'(rspQ.pop_front());
        end
        checkVal("req_ready", 32'(bus.req_ready_o), 32'(expReady));
        checkVal("dp_enable", 32'(bus.dp_enable_o), 32'(xfer));
        checkVal("dp_data",   32'(bus.dp_data_o),   32'(expData));
        checkVal("rsp_valid", 32'(bus.rsp_valid_o), 32'(expRspV));
        checkVal("rsp_data",  32'(bus.rsp_data_o),  32'(expRspD));
`ifdef MODULE3_ARBITER_STATS_EN
        checkVal("stat_bursts",    32'(statBursts),    32'(mBursts));
        checkVal("stat_conflicts", 32'(statConflicts), 32'(mConflicts));
`endif
        nv = $countones(bus.req_valid_i);
        if (!mGranted) begin
            if (nv >= 2) mConflicts = (mConflicts + 1) % 65536;
            found = 1'b0;
            for (int i = 0; i < N; i++) begin
                if (!found && bus.req_valid_i[(mPtr + i) % N]) begin
                    mOwner = (mPtr + i) % N;
                    found  = 1'b1;
                end
            end
            if (found) begin
                mGranted = 1'b1;
                mBeats   = 0;
            end
        end else if (!xfer) begin
            endBurst();
        end else begin
            mBeats++;
            rspQ.push_back('{cycle + L + 1, mOwner, slice ^ DP_KEY});
            if (bus.req_last_i[mOwner] || mBeats == MB) endBurst();
        end
        cycle++;
    endtask

    // Drive one cycle of requester inputs (called at posedge+1) and check it.
    task automatic applyStimulus(input logic [3:0] v, input logic [3:0] l, input logic [31:0] d);
        bus.req_valid_i = v;
        bus.req_last_i  = l;
        bus.req_data_i  = d;
        @(negedge clk);
        checkOutput();
        @(posedge clk);
        #1;
    endtask

    task automatic checkAllZero(input string tag);
        checkVal({tag, "_ready"},  32'(bus.req_ready_o), 32'h0);
        checkVal({tag, "_enable"}, 32'(bus.dp_enable_o), 32'h0);
        checkVal({tag, "_dpdata"}, 32'(bus.dp_data_o),   32'h0);
        checkVal({tag, "_rspv"},   32'(bus.rsp_valid_o), 32'h0);
        checkVal({tag, "_rspd"},   32'(bus.rsp_data_o),  32'h0);
    endtask

    initial begin
        logic [3:0] v, l;
        bus.req_valid_i = '0;
        bus.req_last_i  = '0;
        bus.req_data_i  = '0;

        // Reset state.
        repeat (3) @(posedge clk);
        #1 checkAllZero("reset");
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Requester 2: three beats 0x11, 0x22, 0x33 with last on the third.
        $display("[TB] single requester burst");
        applyStimulus(4'b0100, 4'b0000, 32'h0011_0000);
        applyStimulus(4'b0100, 4'b0000, 32'h0011_0000);
        applyStimulus(4'b0100, 4'b0000, 32'h0022_0000);
        applyStimulus(4'b0100, 4'b0100, 32'h0033_0000);
        repeat (6) applyStimulus(4'b0000, 4'b0000, 32'h0);

        // All requesters continuously valid, never last: five full bursts and more.
        $display("[TB] all requesters valid");
        repeat (26) applyStimulus(4'b1111, 4'b0000, $urandom);
        repeat (6) applyStimulus(4'b0000, 4'b0000, 32'h0);

        // Requester 1 drops valid after two beats, then competes with requester 2.
        $display("[TB] gap terminates burst");
        applyStimulus(4'b0010, 4'b0000, $urandom);
        applyStimulus(4'b0010, 4'b0000, $urandom);
        applyStimulus(4'b0010, 4'b0000, $urandom);
        applyStimulus(4'b0000, 4'b0000, $urandom);
        repeat (8) applyStimulus(4'b0110, 4'b0000, $urandom);
        repeat (6) applyStimulus(4'b0000, 4'b0000, 32'h0);

        // Requester 0 two beats, then requester 3 one beat while results are in flight.
        $display("[TB] ownership across grant change");
        applyStimulus(4'b0001, 4'b0000, 32'h0000_00A1);
        applyStimulus(4'b1001, 4'b0000, 32'h0000_00A1);
        applyStimulus(4'b1001, 4'b0001, 32'h0000_00A2);
        applyStimulus(4'b1000, 4'b0000, 32'hB300_0000);
        applyStimulus(4'b1000, 4'b1000, 32'hB300_0000);
        repeat (6) applyStimulus(4'b0000, 4'b0000, 32'h0);

        // Reset mid-burst with two beats in flight.
        $display("[TB] reset mid-burst");
        applyStimulus(4'b0100, 4'b0000, 32'h0055_0000);
        applyStimulus(4'b0100, 4'b0000, 32'h0055_0000);
        applyStimulus(4'b0100, 4'b0000, 32'h0066_0000);
        bus.req_valid_i = 4'b0100;
        bus.req_data_i  = 32'h0077_0000;
        #2 rst_n = 1'b0;
        #1 checkAllZero("async_reset");
        @(posedge clk);
        #1 bus.req_valid_i = 4'b0000;
        #2 rst_n = 1'b1;
        modelReset();
        @(posedge clk);
        #1;
        repeat (4) applyStimulus(4'b1010, 4'b0000, $urandom);
        repeat (8) applyStimulus(4'b0000, 4'b0000, 32'h0);

        // Random traffic.
        $display("[TB] random traffic");
        for (int c = 0; c < 400; c++) begin
            for (int k = 0; k < N; k++) begin
                v[k] = ($urandom_range(0, 9) < 7);
                l[k] = ($urandom_range(0, 9) < 2);
            end
            if ($urandom_range(0, 19) == 0) v = 4'b0000;
            applyStimulus(v, l, $urandom);
        end
        repeat (6) applyStimulus(4'b0000, 4'b0000, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end
endmodule
